decode_fifo_mw: RTL and testbench
=================================

Name: decode_fifo_mw

Overview:
- Parametrised multi-lane decoded-instruction buffer between fetch/pre-decode and issue.
- Accepts up to ENQ_W instructions per cycle and presents up to DEQ_W in program order.
- Computes the in-delay-slot flag across cycles and withholds a branch/jump from issue until its delay slot is also presentable.
- Successor to the single-lane fetch→decode handoff; enables dual issue.

Parameters:
DEPTH, 16, entry count; power of two, >= ENQ_W+DEQ_W
ENQ_W, 2, enqueue lanes per cycle (1..4)
DEQ_W, 2, dequeue lanes per cycle (1..4)
EXC_W, 3, per-instruction fetch exception bits (i_tlb_refill, i_tlb_invalid, addr error)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  discard all entries (exception/eret/mispredict redirect)
in_valid  in  ENQ_W  per-lane valid; lane i used only if lanes 0..i all valid
in_instr  in  ENQ_W*32  raw instruction words, lane 0 oldest
in_pc  in  ENQ_W*32  instruction PCs
in_is_branch  in  ENQ_W  instruction has a delay slot (branch, j, jal, jr, jalr)
in_exc  in  ENQ_W*EXC_W  fetch exception bits
in_ready  out  1  free slots >= ENQ_W (from registered count)
out_valid  out  DEQ_W  per-lane presentable, contiguous from lane 0
out_instr  out  DEQ_W*32  head entries, lane 0 = oldest
out_pc  out  DEQ_W*32  PCs
out_is_branch  out  DEQ_W  branch flag
out_in_delay_slot  out  DEQ_W  entry follows a branch in program order
out_exc  out  DEQ_W*EXC_W  exception bits
deq_cnt  in  $clog2(DEQ_W+1)  entries consumed this cycle; <= popcount(out_valid)
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (resetn low, async): rd/wr pointers 0, count 0, last_was_branch 0; out_valid 0, in_ready 1, count 0. Data regs need no reset.
- Storage: circular array, pointers with one extra wrap bit; full when count == DEPTH; indices wrap mod DEPTH.
- Enqueue: n_in = number of leading valid lanes; written only when in_ready; in_valid ignored when in_ready low (fetch holds).
- Delay-slot tag at enqueue: lane 0 tagged with last_was_branch; lane i>0 tagged with in_is_branch of lane i-1. last_was_branch <= in_is_branch of the last accepted lane; unchanged if n_in == 0.
- Latency: entry written at edge N visible on out_* in cycle N+1; no bypass.
- Presentation: lane k valid iff k < count and no earlier lane withheld; a branch in lane k is withheld (out_valid[k]=0, and all higher lanes 0) unless k+1 < DEQ_W and k+1 < count. With DEQ_W=1 a branch presents alone (issue handles the delay slot serially); rule applies only for DEQ_W>=2.
- Dequeue: rd_ptr += deq_cnt; deq_cnt > popcount(out_valid) is a protocol error (assertion in simulation, behaviour undefined).
- Simultaneous enq/deq: count_next = count + n_in - deq_cnt; in_ready uses registered count only.
- Flush: synchronous, highest priority; next cycle count 0, pointers equal, last_was_branch 0; same-cycle enqueue and dequeue discarded.
- Wrap-around: multi-lane writes and reads span the DEPTH-1→0 boundary seamlessly.
- out_* data lanes where out_valid=0 are don't-care.

Test Plan:
- Reset then enqueue 2 ALU instrs (pc 0xBFC00000, 0xBFC00004) → next cycle out_valid=2'b11, count=2, in_delay_slot=2'b00.
- Enqueue BEQ alone (pc 0x100), next cycle its slot (pc 0x104) → cycle 1 out_valid=2'b00 (branch withheld); cycle 2 out_valid=2'b11, in_delay_slot=2'b10.
- Head ALU, BEQ, slot with DEQ_W=2 → out_valid=2'b01; after deq_cnt=1, out_valid=2'b11 with BEQ in lane 0.
- Fill to 16 with deq_cnt=0 → in_ready drops at count 15 (16-15 < 2); dequeue 2 → in_ready=1 next cycle.
- Run 40 enq/deq cycles with random legal deq_cnt → PC order preserved across pointer wrap, count matches model.
- Flush with in_valid=2'b11 and deq_cnt=2 same cycle → next cycle count=0, out_valid=0, last_was_branch cleared (next lane-0 entry has in_delay_slot=0).

Source files
------------

// File: rtl/decode_fifo_mw_if.sv
// Bus bundle between fetch/pre-decode, the decoded-instruction buffer and issue.
//
// Handshake: the enqueue side presents lanes in in_valid, contiguous from lane 0.
// Lanes are taken only in a cycle where in_ready is high and flush is low.
// in_ready comes from the registered occupancy only. Fetch holds its lanes
// while in_ready is low. The dequeue side may consume deq_cnt entries in a
// cycle, where deq_cnt <= popcount(out_valid). out_valid is contiguous from
// lane 0, and lane 0 is the oldest entry.
interface decode_fifo_mw_if #(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2,
  parameter int EXC_W = 3
);
  localparam int DC_W  = $clog2(DEQ_W + 1);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   flush;
  logic [ENQ_W-1:0]       in_valid;
  logic [ENQ_W*32-1:0]    in_instr;
  logic [ENQ_W*32-1:0]    in_pc;
  logic [ENQ_W-1:0]       in_is_branch;
  logic [ENQ_W*EXC_W-1:0] in_exc;
  logic                   in_ready;
  logic [DEQ_W-1:0]       out_valid;
  logic [DEQ_W*32-1:0]    out_instr;
  logic [DEQ_W*32-1:0]    out_pc;
  logic [DEQ_W-1:0]       out_is_branch;
  logic [DEQ_W-1:0]       out_in_delay_slot;
  logic [DEQ_W*EXC_W-1:0] out_exc;
  logic [DC_W-1:0]        deq_cnt;
  logic [CNT_W-1:0]       count;

  // Buffer side
  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_is_branch, in_exc, deq_cnt,
    output in_ready, out_valid, out_instr, out_pc, out_is_branch,
           out_in_delay_slot, out_exc, count
  );

  // Fetch/issue side
  modport master (
    output flush, in_valid, in_instr, in_pc, in_is_branch, in_exc, deq_cnt,
    input  in_ready, out_valid, out_instr, out_pc, out_is_branch,
           out_in_delay_slot, out_exc, count
  );
endinterface

// File: rtl/decode_fifo_mw.sv
// Multi-lane decoded-instruction buffer. It sits between fetch/pre-decode and issue.
// The buffer tags each entry with its delay-slot status. It holds back a branch
// until the branch's delay slot can be presented in the same group.
module decode_fifo_mw #(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2,
  parameter int EXC_W = 3
) (
  input  logic            clk,
  input  logic            resetn,
  decode_fifo_mw_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DC_W  = $clog2(DEQ_W + 1);
  localparam int NI_W  = $clog2(ENQ_W + 1);

  // Control state. The pointers carry one extra wrap bit.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_last_br;

  // Entry storage. No reset is needed, because r_count qualifies every read.
  logic [31:0]      r_instr [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic             r_br    [DEPTH];
  logic             r_ds    [DEPTH];
  logic [EXC_W-1:0] r_exc   [DEPTH];

  logic             w_in_ready;
  logic [NI_W-1:0]  w_n_lead;
  logic             w_run;
  logic [NI_W-1:0]  w_n_in;
  logic [ENQ_W-1:0] w_ds_in;
  logic             w_last_br_nxt;
  logic [PTR_W-1:0] w_wr_idx [ENQ_W];
  logic [PTR_W-1:0] w_rd_idx [DEQ_W];
  logic [DEQ_W-1:0] w_out_valid;
  logic             w_block;
  logic             w_have;
  logic             w_have_next;
  logic [DC_W-1:0]  w_pop;

  // Space for a full enqueue group. This uses the registered occupancy only.
  assign w_in_ready = (DEPTH - int'(r_count)) >= ENQ_W;

  // Count the leading valid lanes. A gap ends the group.
  always_comb begin
    w_n_lead = '0;
    w_run    = 1'b1;
    for (int i = 0; i < ENQ_W; i++) begin
      if (w_run && bus.in_valid[i]) w_n_lead = w_n_lead + NI_W'(1);
      else                          w_run    = 1'b0;
    end
  end

  // Lanes accepted this cycle. No lanes are accepted when the buffer is not ready or when it is being flushed.
  assign w_n_in = (w_in_ready && !bus.flush) ? w_n_lead : '0;

  // Delay-slot tags for incoming lanes, and the branch flag of the youngest accepted lane.
  always_comb begin
    w_ds_in       = '0;
    w_ds_in[0]    = r_last_br;
    for (int i = 1; i < ENQ_W; i++) w_ds_in[i] = bus.in_is_branch[i-1];
    w_last_br_nxt = r_last_br;
    for (int i = 0; i < ENQ_W; i++) begin
      if (NI_W'(i) < w_n_in) w_last_br_nxt = bus.in_is_branch[i];
    end
  end

  // Per-lane storage indices. The truncation to PTR_W bits wraps them mod DEPTH.
  always_comb begin
    for (int i = 0; i < ENQ_W; i++) w_wr_idx[i] = r_wr_ptr[PTR_W-1:0] + PTR_W'(i);
    for (int k = 0; k < DEQ_W; k++) w_rd_idx[k] = r_rd_ptr[PTR_W-1:0] + PTR_W'(k);
  end

  // Write the accepted lanes into the circular array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (NI_W'(i) < w_n_in) begin
        r_instr[w_wr_idx[i]] <= bus.in_instr[i*32 +: 32];
        r_pc[w_wr_idx[i]]    <= bus.in_pc[i*32 +: 32];
        r_br[w_wr_idx[i]]    <= bus.in_is_branch[i];
        r_ds[w_wr_idx[i]]    <= w_ds_in[i];
        r_exc[w_wr_idx[i]]   <= bus.in_exc[i*EXC_W +: EXC_W];
      end
    end
  end

  // Decide which head lanes can be presented. A branch is held back, together
  // with every younger lane, unless its delay slot is present in the next lane.
  always_comb begin
    w_out_valid = '0;
    w_block     = 1'b0;
    w_have      = 1'b0;
    w_have_next = 1'b0;
    for (int k = 0; k < DEQ_W; k++) begin
      w_have      = CNT_W'(k) < r_count;
      w_have_next = (k + 1 < DEQ_W) && (CNT_W'(k + 1) < r_count);
      if (!w_block && w_have) begin
        if (DEQ_W >= 2 && r_br[w_rd_idx[k]] && !w_have_next) w_block = 1'b1;
        else                                                 w_out_valid[k] = 1'b1;
      end else begin
        w_block = 1'b1;
      end
    end
  end

  // Number of lanes that are presentable this cycle.
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < DEQ_W; k++) w_pop = w_pop + DC_W'(w_out_valid[k]);
  end

  // Drive the head entries onto the output lanes.
  always_comb begin
    bus.out_instr         = '0;
    bus.out_pc            = '0;
    bus.out_is_branch     = '0;
    bus.out_in_delay_slot = '0;
    bus.out_exc           = '0;
    for (int k = 0; k < DEQ_W; k++) begin
      bus.out_instr[k*32 +: 32]         = r_instr[w_rd_idx[k]];
      bus.out_pc[k*32 +: 32]            = r_pc[w_rd_idx[k]];
      bus.out_is_branch[k]              = r_br[w_rd_idx[k]];
      bus.out_in_delay_slot[k]          = r_ds[w_rd_idx[k]];
      bus.out_exc[k*EXC_W +: EXC_W]     = r_exc[w_rd_idx[k]];
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = w_in_ready;
  assign bus.count     = r_count;

  // Update the pointers, the occupancy and the delay-slot carry. Flush has priority over enqueue and dequeue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_last_br <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_last_br <= 1'b0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + (PTR_W+1)'(w_n_in);
      r_rd_ptr  <= r_rd_ptr + (PTR_W+1)'(bus.deq_cnt);
      r_count   <= r_count + CNT_W'(w_n_in) - CNT_W'(bus.deq_cnt);
      r_last_br <= w_last_br_nxt;
    end
  end

  // The issue stage must never consume more entries than are presented.
  deq_legal_a: assert property (@(posedge clk) disable iff (!resetn)
    bus.flush || (bus.deq_cnt <= w_pop));
endmodule

// File: tb/tb_decode_fifo_mw.sv
// Bench for decode_fifo_mw with directed vectors, a model count and an expected-entry queue.
module tb_decode_fifo_mw;
  localparam int DEPTH = 16;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int EXC_W = 3;
  localparam int EW    = 32 + 32 + 1 + 1 + EXC_W;

  logic clk;
  logic resetn;

  decode_fifo_mw_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .EXC_W(EXC_W)) bus ();

  decode_fifo_mw #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .EXC_W(EXC_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: {pc, instr, is_branch, in_delay_slot, exc}
  logic [EW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int m_cnt  = 0;
  logic m_last = 1'b0;
  int last_n = 0;
  logic [EW-1:0] mon_e;
  logic [EW-1:0] mon_a;

  function automatic logic [31:0] f_instr(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic [EXC_W-1:0] f_exc(input logic [31:0] pc);
    return pc[4:2];
  endfunction

  function automatic int pop2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
  endtask

  // Driver: it applies one cycle of stimulus and updates the model. It returns #1 after the edge.
  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] br, input int deq, input logic fl);
    logic ready_m;
    int   n;
    ready_m = (DEPTH - m_cnt) >= ENQ_W;
    chk("in_ready", 32'(bus.in_ready), 32'(ready_m));
    bus.in_valid     = v;
    bus.in_pc        = {pc1, pc0};
    bus.in_instr     = {f_instr(pc1), f_instr(pc0)};
    bus.in_is_branch = br;
    bus.in_exc       = {f_exc(pc1), f_exc(pc0)};
    bus.deq_cnt      = 2'(deq);
    bus.flush        = fl;
    n = 0;
    if (ready_m && !fl && v[0]) n = v[1] ? 2 : 1;
    last_n = n;
    if (fl) begin
      exp_q.delete();
      m_cnt  = 0;
      m_last = 1'b0;
    end else begin
      if (n >= 1) exp_q.push_back({pc0, f_instr(pc0), br[0], m_last, f_exc(pc0)});
      if (n == 2) exp_q.push_back({pc1, f_instr(pc1), br[1], br[0], f_exc(pc1)});
      m_cnt = m_cnt + n - deq;
      if (n == 1) m_last = br[0];
      if (n == 2) m_last = br[1];
    end
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    bus.deq_cnt  = '0;
    bus.flush    = 1'b0;
    chk("count", 32'(bus.count), 32'(m_cnt));
  endtask

  // Monitor: in each cycle that consumes entries, pop the expected entries and compare them with the lanes being taken.
  always @(negedge clk) begin
    if (resetn && !bus.flush) begin
      for (int k = 0; k < int'(bus.deq_cnt); k++) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL deq_underflow lane=%0d act_pc=%h exp=none", k, bus.out_pc[k*32 +: 32]);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = {bus.out_pc[k*32 +: 32], bus.out_instr[k*32 +: 32], bus.out_is_branch[k],
                   bus.out_in_delay_slot[k], bus.out_exc[k*EXC_W +: EXC_W]};
          if (bus.out_valid[k] && mon_a === mon_e) n_pass++;
          else $display("FAIL deq_entry lane=%0d valid=%b act=%h exp=%h", k, bus.out_valid[k], mon_a, mon_e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [31:0] pc_seq;
    logic [1:0]  v;
    logic [1:0]  br;
    int          sel;
    logic        slot_done;
    resetn           = 1'b0;
    bus.flush        = 1'b0;
    bus.in_valid     = '0;
    bus.in_instr     = '0;
    bus.in_pc        = '0;
    bus.in_is_branch = '0;
    bus.in_exc       = '0;
    bus.deq_cnt      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Two ALU instructions are presented together.
    drive(2'b11, 32'hBFC00000, 32'hBFC00004, 2'b00, 0, 1'b0);
    chk("alu_out_valid", 32'(bus.out_valid), 32'b11);
    chk("alu_ds", 32'(bus.out_in_delay_slot), 32'b00);
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2, 1'b0);

    // A branch alone is withheld. It presents once its delay slot arrives.
    drive(2'b01, 32'h100, 32'h0, 2'b01, 0, 1'b0);
    chk("br_alone_valid", 32'(bus.out_valid), 32'b00);
    drive(2'b01, 32'h104, 32'h0, 2'b00, 0, 1'b0);
    chk("br_slot_valid", 32'(bus.out_valid), 32'b11);
    chk("br_slot_ds", 32'(bus.out_in_delay_slot), 32'b10);
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2, 1'b0);

    // With ALU, BEQ and slot queued, the BEQ in lane 1 is withheld until it reaches lane 0.
    drive(2'b11, 32'h200, 32'h204, 2'b10, 0, 1'b0);
    chk("alu_br_valid", 32'(bus.out_valid), 32'b01);
    drive(2'b01, 32'h208, 32'h0, 2'b00, 0, 1'b0);
    chk("alu_br_slot_valid", 32'(bus.out_valid), 32'b01);
    drive(2'b00, 32'h0, 32'h0, 2'b00, 1, 1'b0);
    chk("br_head_valid", 32'(bus.out_valid), 32'b11);
    chk("br_head_pc", bus.out_pc[31:0], 32'h204);
    chk("br_head_isbr", 32'(bus.out_is_branch), 32'b01);
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2, 1'b0);

    // Fill the buffer. in_ready drops once fewer than two slots are free.
    for (int i = 0; i < 7; i++) drive(2'b11, 32'h1000 + 32'(i*8), 32'h1004 + 32'(i*8), 2'b00, 0, 1'b0);
    chk("fill14_ready", 32'(bus.in_ready), 32'd1);
    drive(2'b01, 32'h1038, 32'h0, 2'b00, 0, 1'b0);
    chk("fill15_ready", 32'(bus.in_ready), 32'd0);
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2, 1'b0);
    chk("fill13_ready", 32'(bus.in_ready), 32'd1);
    drive(2'b01, 32'h103C, 32'h0, 2'b00, 0, 1'b0);
    drive(2'b11, 32'h1040, 32'h1044, 2'b00, 0, 1'b0);
    chk("full_count", 32'(bus.count), 32'd16);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    drive(2'b11, 32'hDEAD0000, 32'hDEAD0004, 2'b00, 0, 1'b0);
    chk("full_ignore_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 8; i++) drive(2'b00, 32'h0, 32'h0, 2'b00, 2, 1'b0);

    // Mixed enqueue/dequeue across pointer wrap, with random legal consumption.
    pc_seq = 32'h2000;
    for (int c = 0; c < 40; c++) begin
      sel = $urandom_range(0, 3);
      v   = 2'(sel);
      br  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      drive(v, pc_seq, pc_seq + 32'd4, br, $urandom_range(0, pop2(bus.out_valid)), 1'b0);
      pc_seq = pc_seq + 32'(4 * last_n);
    end
    slot_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (slot_done && m_cnt == 0) break;
      drive(slot_done ? 2'b00 : 2'b01, pc_seq, 32'h0, 2'b00, pop2(bus.out_valid), 1'b0);
      if (last_n == 1) begin
        slot_done = 1'b1;
        pc_seq    = pc_seq + 32'd4;
      end
    end
    chk("drain_count", 32'(bus.count), 32'd0);

    // Flush with a same-cycle enqueue and dequeue. It also clears the delay-slot carry.
    drive(2'b11, 32'h400, 32'h404, 2'b00, 0, 1'b0);
    drive(2'b11, 32'h408, 32'h40C, 2'b10, 0, 1'b0);
    chk("pre_flush_valid", 32'(bus.out_valid), 32'b11);
    drive(2'b11, 32'h410, 32'h414, 2'b00, 2, 1'b1);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'b00);
    drive(2'b01, 32'h500, 32'h0, 2'b00, 0, 1'b0);
    chk("post_flush_valid", 32'(bus.out_valid), 32'b01);
    chk("post_flush_ds", 32'(bus.out_in_delay_slot[0]), 32'd0);
    drive(2'b00, 32'h0, 32'h0, 2'b00, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
